// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter slice.
// The optional draw-bank clear is enabled with FB_CLEAR_ON_SWAP_EN.
package fb_pkg;

    localparam int FB_ADDR_W = 10;
    localparam int FB_DATA_W = 36;

    localparam logic FB_BANK0 = 1'b0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SWAP_PEND = 2'd1,
        CLEAR     = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_clear_sequencer.sv
// Address counter that walks a whole bank once, issuing one zero write per
// cycle the scan leaves the RAM free. Used only when FB_CLEAR_ON_SWAP_EN is defined.
module fb_clear_sequencer
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_scan_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_done
);

    logic [ADDR_W-1:0] r_cnt;
    logic              w_adv;

    // A scan cycle owns the RAM, so the counter simply holds its place.
    assign w_adv = i_enable & ~i_scan_req;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!i_enable) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_addr = r_cnt;
    assign o_we   = w_adv;
    assign o_done = w_adv & (r_cnt == {ADDR_W{1'b1}});

endmodule

// File: rtl/framebuffer_arbiter.sv
// Double-buffered frame RAM arbiter: scan reads the display bank, host writes the draw bank.
// Optional draw-bank clear after each swap is enabled with FB_CLEAR_ON_SWAP_EN.
module framebuffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_rvalid,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              display_bank,
    output logic              clear_busy,
    output logic [ADDR_W:0]   ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output fb_state_t         dbg_state
);

    // Host handshake: a write transfers on any cycle where wr_valid & wr_ready;
    // wr_ready never waits on wr_valid, and the scan port has no backpressure.

    fb_state_t         r_state;
    fb_state_t         w_next_state;
    logic              r_display_bank;
    logic              r_scan_rvalid;
    logic              r_swap_done;
    logic              w_swap_fire;
    logic              w_wr_fire;
    logic              w_in_clear;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    assign w_in_clear = (r_state == CLEAR);

`ifdef FB_CLEAR_ON_SWAP_EN
    logic w_clr_done;

    fb_clear_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_in     (clk_in),
        .reset      (reset),
        .i_enable   (w_in_clear),
        .i_scan_req (scan_req),
        .o_addr     (w_clr_addr),
        .o_we       (w_clr_we),
        .o_done     (w_clr_done)
    );

    assign clear_busy = w_in_clear;
`else
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
    assign clear_busy = 1'b0;
`endif

    // Gated by reset so no write can be accepted while reset is held.
    assign wr_ready  = reset & ~scan_req & ~w_in_clear;
    assign w_wr_fire = wr_valid & wr_ready;

    always_comb begin
        w_next_state = r_state;
        w_swap_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                // frame_start here is irrelevant: a same-cycle request waits for the next frame.
                if (swap_req) begin
                    w_next_state = SWAP_PEND;
                end
            end
            SWAP_PEND: begin
                if (frame_start) begin
                    w_swap_fire = 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
                    w_next_state = CLEAR;
`else
                    w_next_state = IDLE;
`endif
                end
            end
            CLEAR: begin
`ifdef FB_CLEAR_ON_SWAP_EN
                if (w_clr_done) begin
                    w_next_state = IDLE;
                end
`else
                w_next_state = IDLE;
`endif
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_display_bank <= FB_BANK0;
            r_scan_rvalid  <= 1'b0;
            r_swap_done    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_scan_rvalid <= scan_req;
            r_swap_done   <= w_swap_fire;
            if (w_swap_fire) begin
                r_display_bank <= ~r_display_bank;
            end
        end
    end

    // The bank register still holds its pre-toggle value during the swap cycle,
    // so a write accepted then lands in the outgoing draw bank.
    always_comb begin
        ram_addr  = {r_display_bank, scan_addr};
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (scan_req) begin
            ram_addr = {r_display_bank, scan_addr};
        end else if (w_clr_we) begin
            ram_addr = {~r_display_bank, w_clr_addr};
            ram_we   = 1'b1;
        end else if (w_wr_fire) begin
            ram_addr  = {~r_display_bank, wr_addr};
            ram_we    = 1'b1;
            ram_wdata = wr_data;
        end
    end

    assign scan_rdata   = ram_rdata;
    assign scan_rvalid  = r_scan_rvalid;
    assign swap_done    = r_swap_done;
    assign display_bank = r_display_bank;
    assign dbg_state    = r_state;

endmodule
